mouse_frame_sync: RTL
=====================

Name: mouse_frame_sync

Overview:
Frame-coherent mouse position publisher in the 65 MHz pixel domain. It accepts already-synchronized mouse coordinate samples and clamps them to the visible area. It commits them to the drawing pipeline only at the start of vertical blanking, so cursor and turret never tear mid-frame. It also hands each committed position to one downstream consumer (turret-angle logic) over a valid/ready handshake and flags a stalled mouse.

Parameters:
- SCREEN_W, 1024, visible width in pixels; X clamp max = SCREEN_W-1
- SCREEN_H, 768, visible height in pixels; Y clamp max = SCREEN_H-1
- STALE_FRAMES, 120, consecutive vblank starts without a sample before `stale` asserts; range 1..255

Ports:
- clk, in, 1, 65 MHz pixel clock
- rst, in, 1, reset: synchronous, active-high
- in_posX, in, 12, raw mouse X, unsigned
- in_posY, in, 12, raw mouse Y, unsigned
- in_valid, in, 1, one-cycle strobe; in_posX/in_posY valid
- vblank, in, 1, level, high during vertical blanking (from VGA timing)
- posX, out, 12, committed X, stable for a whole frame
- posY, out, 12, committed Y
- pos_update, out, 1, one-cycle pulse on the cycle posX/posY change
- evt_valid, out, 1, committed position offered to consumer
- evt_ready, in, 1, consumer accepts when evt_valid && evt_ready
- overrun, out, 1, sticky: a commit occurred while evt_valid was still pending
- stale, out, 1, mouse silent for STALE_FRAMES frames

Behaviour:
- Reset:
  - posX=0, posY=0; pos_update=0, evt_valid=0, overrun=0, stale=0.
  - Shadow regs 0, pending=0, vblank_d=0, stale counter 0, FSM=IDLE.
  - Reset mid-operation discards any pending sample and any unaccepted event.
- Clamp (combinational on input):
  - X = min(in_posX, SCREEN_W-1); Y = min(in_posY, SCREEN_H-1).
  - Unsigned 12-bit compare; no wrap.
- Capture: every in_valid writes the clamped values to the shadow regs and sets pending. Last sample wins; earlier uncommitted samples are dropped silently.
- Frame edge: vb_rise = vblank && !vblank_d. vblank_d is registered each cycle.
- FSM:
  - IDLE: pending=0. Enter ARMED on in_valid.
  - ARMED: pending=1. On vb_rise go to COMMIT.
  - COMMIT: single cycle.
    - posX/posY <= shadow; pos_update=1 this cycle; pending cleared.
    - If evt_valid is already 1, set overrun.
    - evt_valid <= 1.
    - Next state is ARMED if in_valid is high this cycle, else IDLE.
- Commit latency: vb_rise seen at cycle N → COMMIT at N+1 → new posX/posY visible at N+2.
- Simultaneous in_valid and vb_rise in ARMED: shadow takes the new sample, and that new sample is the one committed.
- Simultaneous in_valid in COMMIT: the committed value is the pre-existing shadow. The new sample is held pending for the next frame.
- vb_rise in IDLE: no commit, no pos_update; outputs unchanged.
- Handshake (independent of FSM):
  - evt_valid falls the cycle after evt_valid && evt_ready.
  - If a COMMIT coincides with acceptance, evt_valid stays 1 and overrun is not set.
  - posX/posY double as evt payload and never change while evt_valid=1, except by a new COMMIT.
- Stale timer:
  - 8-bit counter increments on vb_rise when no in_valid has arrived since the previous vb_rise.
  - Saturates at STALE_FRAMES; stale = (count == STALE_FRAMES).
  - Any in_valid clears count and stale next cycle. In_valid and vb_rise in the same cycle count as activity.
- overrun clears only on rst.

Decomposition:
- Package mouse_pkg:
  - SCREEN_W/SCREEN_H defaults and COORD_W=12.
  - FSM state enum {IDLE, ARMED, COMMIT}.
- One sub-module: frame_stale_timer.
  - Inputs: clk, rst, tick=vb_rise, activity=in_valid.
  - Output: stale.
  - Parameter: STALE_FRAMES.
- Clamp and FSM stay in the top.

Test Plan:
- Basic commit: in_valid with (100,200) mid-frame, vblank rises at cycle N → posX=100, posY=200 and pos_update=1 at N+2; unchanged before.
- Clamp and last-wins: samples (2000,900) then (1500,50) in one frame → committed (1023,50); first sample never appears.
- Simultaneous events:
  - in_valid (10,10) on the same cycle as vb_rise in ARMED → (10,10) committed.
  - in_valid (20,20) during COMMIT → (20,20) appears only after the next vblank rise.
- Handshake and overrun:
  - evt_ready held 0 across two frames with new samples → evt_valid stays 1, overrun=1, posX shows the second value.
  - evt_ready=1 on a non-commit cycle → evt_valid=0 the next cycle.
- Stale: STALE_FRAMES=3, no in_valid for 3 vblank rises → stale=1 after the third; an in_valid → stale=0 next cycle.
- Reset mid-operation: rst while ARMED with evt_valid=1 → all outputs 0; the following vblank produces no pos_update.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants, FSM state type and coordinate clamp for the mouse frame-sync block.
package mouse_pkg;

  localparam int unsigned COORD_W      = 12;
  localparam int unsigned SCREEN_W_DEF = 1024;
  localparam int unsigned SCREEN_H_DEF = 768;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT
  } state_e;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/frame_stale_timer.sv
// Counts vblank starts with no mouse activity in between; flags a stalled mouse.
module frame_stale_timer #(
  parameter int unsigned STALE_FRAMES = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic activity,
  output logic stale
);

  localparam logic [7:0] Limit = 8'(STALE_FRAMES);

  logic [7:0] count;
  logic       seen;

  // seen remembers activity since the previous tick so the next tick does not count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      seen  <= 1'b0;
    end else if (activity) begin
      count <= '0;
      seen  <= 1'b1;
    end else if (tick) begin
      if (!seen && count != Limit) count <= count + 8'd1;
      seen <= 1'b0;
    end
  end

  assign stale = (count == Limit);

endmodule

// File: rtl/mouse_frame_sync.sv
// Clamps mouse samples and commits them only at vblank start; offers each commit downstream.
module mouse_frame_sync
  import mouse_pkg::*;
#(
  parameter int unsigned SCREEN_W     = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H     = SCREEN_H_DEF,
  parameter int unsigned STALE_FRAMES = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] in_posX,
  input  logic [COORD_W-1:0] in_posY,
  input  logic               in_valid,
  input  logic               vblank,
  output logic [COORD_W-1:0] posX,
  output logic [COORD_W-1:0] posY,
  output logic               pos_update,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic               overrun,
  output logic               stale
);

  localparam logic [COORD_W-1:0] XMax = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YMax = COORD_W'(SCREEN_H - 1);

  state_e             state;
  logic [COORD_W-1:0] shadow_x, shadow_y;
  logic               pending;
  logic               vblank_d;
  logic               vb_rise;
  logic [COORD_W-1:0] clamp_x, clamp_y;

  assign vb_rise = vblank && !vblank_d;
  assign clamp_x = clamp_coord(in_posX, XMax);
  assign clamp_y = clamp_coord(in_posY, YMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow_x   <= '0;
      shadow_y   <= '0;
      pending    <= 1'b0;
      vblank_d   <= 1'b0;
      posX       <= '0;
      posY       <= '0;
      pos_update <= 1'b0;
      evt_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vblank_d   <= vblank;
      pos_update <= 1'b0;
      if (in_valid) begin
        shadow_x <= clamp_x;
        shadow_y <= clamp_y;
        pending  <= 1'b1;
      end
      if (evt_valid && evt_ready) evt_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) state <= ARMED;
        end
        ARMED: begin
          if (vb_rise && pending) state <= COMMIT;
        end
        COMMIT: begin
          // Commits the shadow as it stood before this cycle; a sample arriving now waits a frame
          posX       <= shadow_x;
          posY       <= shadow_y;
          pos_update <= 1'b1;
          evt_valid  <= 1'b1;
          if (evt_valid && !evt_ready) overrun <= 1'b1;
          pending <= in_valid;
          state   <= in_valid ? ARMED : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  frame_stale_timer #(
    .STALE_FRAMES(STALE_FRAMES)
  ) u_stale (
    .clk     (clk),
    .rst     (rst),
    .tick    (vb_rise),
    .activity(in_valid),
    .stale   (stale)
  );

endmodule
